// File: rtl/booth_r4_seq_mult.sv
// +-----------------------------------------------------------------------------+
// | booth_r4_seq_mult: iterative radix-4 Booth multiplier, one digit per cycle,  |
// | signed/unsigned operands, valid/ready on both sides.        Rev 1.0          |
// +-----------------------------------------------------------------------------+
`default_nettype none

module booth_r4_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic                 busy
);

  localparam int AW = 2*WIDTH + 4;            // accumulator width
  localparam int PW = WIDTH + 2;              // extended multiplicand / partial product
  localparam int MW = WIDTH + 3;              // multiplier with b[-1] and two extension bits
  localparam int CW = $clog2(WIDTH/2 + 2);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("booth_r4_seq_mult: WIDTH must be even and >= 4");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   a_q, a_d;
  logic [MW-1:0]   m_q, m_d;
  logic            sgn_q, sgn_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   acc_q, acc_d;

  logic [PW-1:0]   pp;
  logic [AW-1:0]   pp_ext;
  logic [AW-1:0]   pp_sh;
  logic [CW-1:0]   last_digit;
  logic            b_ext;

  // The low three bits of the shifting multiplier register are always the
  // current Booth triplet {b[2i+1], b[2i], b[2i-1]}.
  always_comb begin
    pp = '0;
    case (m_q[2:0])
      3'b001, 3'b010: pp = a_q;
      3'b011:         pp = a_q << 1;
      3'b100:         pp = -(a_q << 1);
      3'b101, 3'b110: pp = -a_q;
      default:        pp = '0;
    endcase
  end

  assign pp_ext     = {{(AW-PW){pp[PW-1]}}, pp};
  assign pp_sh      = pp_ext << {cnt_q, 1'b0};
  assign last_digit = sgn_q ? CW'(WIDTH/2 - 1) : CW'(WIDTH/2);
  assign b_ext      = in_signed & in_b[WIDTH-1];

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    m_d       = m_q;
    sgn_d     = sgn_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_p     = '0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = in_signed ? {{2{in_a[WIDTH-1]}}, in_a} : {2'b00, in_a};
          m_d     = {b_ext, b_ext, in_b, 1'b0};
          sgn_d   = in_signed;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        busy  = 1'b1;
        acc_d = acc_q + pp_sh;
        m_d   = m_q >> 2;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == last_digit) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        out_p     = acc_q[2*WIDTH-1:0];
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      m_q     <= '0;
      sgn_q   <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      sgn_q   <= sgn_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_booth_r4_seq_mult.sv
// +-----------------------------------------------------------------------------+
// | tb_booth_r4_seq_mult: scoreboard bench for booth_r4_seq_mult (WIDTH=8).     |
// |                                                             Rev 1.0          |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_booth_r4_seq_mult;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic           in_signed;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_p;
  logic           busy;

  int tests = 0;
  int fails = 0;
  logic [2*W-1:0] sb_q[$];
  bit bp_en   = 1'b0;
  bit rdy_ctl = 1'b1;

  booth_r4_seq_mult #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer multiply, truncated to the product width.
  function automatic logic [2*W-1:0] ref_mult(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    int x, y, p;
    if (s) begin
      x = int'($signed(a));
      y = int'($signed(b));
    end else begin
      x = int'(a);
      y = int'(b);
    end
    p = x * y;
    return p[2*W-1:0];
  endfunction

  // Consumer side: backpressure either random or under direct control.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = bp_en ? ($urandom_range(0, 3) != 0) : rdy_ctl;
    end
  end

  // Monitor: every accepted product is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_product", 32'(out_p), 32'hDEAD_BEEF);
      end else begin
        check("product", 32'(out_p), 32'(sb_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    int to = 0;
    while (!in_ready && to < 64) begin
      step();
      to++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_signed = s;
    in_a      = a;
    in_b      = b;
    sb_q.push_back(ref_mult(s, a, b));
    step();
    in_valid = 1'b0;
  endtask

  // Runs from acceptance until out_valid; latency counts the accepting edge as edge 1.
  task automatic do_op(input bit s, input logic [W-1:0] a, input logic [W-1:0] b, input bit scramble);
    int edges = 1;
    int busy_cnt = 0;
    int n = s ? W/2 : W/2 + 1;
    start_op(s, a, b);
    while (!out_valid && edges < 20) begin
      if (busy) busy_cnt++;
      if (scramble) begin
        in_valid  = $urandom_range(0, 1) != 0;
        in_signed = $urandom_range(0, 1) != 0;
        in_a      = W'($urandom);
        in_b      = W'($urandom);
      end
      step();
      edges++;
    end
    in_valid = 1'b0;
    check(s ? "latency_signed" : "latency_unsigned", 32'(edges), 32'(n + 1));
    check("busy_cycles", 32'(busy_cnt), 32'(n));
  endtask

  task automatic finish_op();
    int to = 0;
    while (out_valid && to < 64) begin
      step();
      to++;
    end
    check("out_valid_drop", 32'(out_valid), 32'd0);
  endtask

  typedef struct {
    bit             s;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t dir_tbl[6] = '{
    '{1'b1, 8'h80, 8'h80, 16'h4000},
    '{1'b0, 8'hFF, 8'hFF, 16'hFE01},
    '{1'b1, 8'hFF, 8'hFF, 16'h0001},
    '{1'b1, 8'h7F, 8'hFF, 16'hFF81},
    '{1'b1, 8'h00, 8'h9C, 16'h0000},
    '{1'b0, 8'h03, 8'hAA, 16'h01FE}
  };

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_signed = 1'b0;
    in_a      = '0;
    in_b      = '0;
    repeat (3) step();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_p", 32'(out_p), 32'd0);
    rst_n = 1'b1;
    step();

    foreach (dir_tbl[i]) begin
      do_op(dir_tbl[i].s, dir_tbl[i].a, dir_tbl[i].b, 1'b0);
      check("directed_p", 32'(out_p), 32'(dir_tbl[i].p));
      finish_op();
    end

    // Operand churn while busy must not disturb the captured operands.
    do_op(1'b1, 8'hA5, 8'h3C, 1'b1);
    finish_op();
    do_op(1'b0, 8'hC3, 8'hE7, 1'b1);
    finish_op();

    // Backpressure: hold the product for three cycles, then release.
    rdy_ctl = 1'b0;
    step();
    do_op(1'b1, 8'h9B, 8'h71, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_p", 32'(out_p), 32'(ref_mult(1'b1, 8'h9B, 8'h71)));
      check("bp_in_ready", 32'(in_ready), 32'd0);
      if (k < 2) step();
    end
    rdy_ctl = 1'b1;
    step();
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    check("bp_release_p", 32'(out_p), 32'd0);

    // Reset in the second CALC cycle aborts with no product.
    start_op(1'b0, 8'h5A, 8'hC7);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    void'(sb_q.pop_back());
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_p", 32'(out_p), 32'd0);
    for (int k = 0; k < 2; k++) begin
      step();
      check("abort_hold_valid", 32'(out_valid), 32'd0);
    end
    rst_n = 1'b1;
    step();
    do_op(1'b1, 8'hE3, 8'h4D, 1'b0);
    finish_op();

    // Randomised operands in both modes with random backpressure.
    bp_en = 1'b1;
    for (int mode = 0; mode < 2; mode++) begin
      for (int n = 0; n < 1000; n++) begin
        do_op(mode[0], W'($urandom), W'($urandom), $urandom_range(0, 3) == 0);
        finish_op();
        if ($urandom_range(0, 3) == 0) step();
      end
    end
    bp_en = 1'b0;
    repeat (4) step();
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
